multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder. Same decode role, now driving a shared-memory datapath through an FSM: FETCH, DECODE, EXEC, MEM, WB.
- Decodes the full RV32I base set except FENCE/SYSTEM, which are flagged illegal.
- Handles variable-latency instruction/data memory via req/ready handshakes, with a timeout watchdog, sticky error flags and a retired-instruction counter.

Parameters:
TIMEOUT_EN, 1, 1 enables the memory wait watchdog; 0 waits forever
TIMEOUT_W, 8, watchdog counter width; timeout fires at 2^TIMEOUT_W-1 wait cycles
CNT_W, 32, width of instret counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
instr  in  32  instruction register contents (IR written by ir_wren)
br_less  in  1  BRC less-than result
br_equal  in  1  BRC equal result
imem_ready  in  1  instruction memory completes request this cycle
dmem_ready  in  1  data memory completes request this cycle
imem_req  out  1  instruction fetch request
ir_wren  out  1  latch imem data into IR
dmem_req  out  1  data memory request
mem_wren  out  1  store (qualifies dmem_req)
lsu_size  out  3  funct3 passthrough for LSU width/sign
alu_q_wren  out  1  datapath registers ALU result into alu_q
pc_wren  out  1  PC update
pc_sel  out  2  0 pc+4, 1 live ALU result, 2 alu_q (datapath clears bit 0)
rd_wren  out  1  regfile write
br_un  out  1  unsigned compare
opa_sel  out  2  0 rs1, 1 pc, 2 zero
opb_sel  out  1  0 rs2, 1 imm
alu_op  out  4  ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110, SLL 0111, SRL 1000, SRA 1001
wb_sel  out  2  0 alu, 1 load data, 2 pc+4
insn_vld  out  1  current instruction decoded legal (DECODE..WB)
retire  out  1  one-cycle pulse when instruction completes
illegal  out  1  sticky illegal-instruction flag
bus_err  out  1  sticky memory timeout flag
instret  out  CNT_W  retired instruction count, wraps modulo 2^CNT_W
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5

Behaviour:
- Reset (rst=1 at edge): state=FETCH; illegal, bus_err, instret, watchdog cleared. During the rst=1 cycle all outputs except state are forced 0. Reset mid-MEM/WB aborts with no write.
- All controls are combinational from state+instr. illegal, bus_err, instret, state and the watchdog are registered.
- FETCH: imem_req=1 until imem_ready; that cycle ir_wren=1, then DECODE.
- DECODE: one cycle. Illegal → HALT, else EXEC.
- Illegal cases:
  - unknown opcode;
  - R-type funct7 not 0000000, or 0100000 with funct3 not 000/101;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 >010;
  - JALR funct3≠000;
  - SLLI funct7≠0;
  - SRLI/SRAI funct7 not 0000000/0100000.
- EXEC, with alu_q_wren=1:
  - R-type: opa rs1, opb rs2, alu_op from funct3/funct7[5].
  - I-type: opb imm; funct7 ignored for ADDI (never SUB); SRAI when instr[30]=1.
  - LUI: opa zero, imm, ADD.
  - AUIPC: opa pc, imm, ADD.
  - JAL: opa pc, imm, ADD.
  - JALR: rs1, imm, ADD.
  - Load/store: rs1, imm, ADD → MEM.
  - Branch: opa pc, imm, ADD; pc_wren=1; pc_sel=1 if taken else 0; retire=1 → FETCH. Taken: BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less; br_un=1 for BLTU/BGEU.
  - All others → WB.
- MEM: dmem_req=1, lsu_size=funct3, mem_wren=1 for stores, held until dmem_ready.
  - Store: on ready, pc_wren=1, pc_sel=0, retire=1 → FETCH.
  - Load: on ready → WB.
- WB: rd_wren=1, pc_wren=1, retire=1 → FETCH.
  - wb_sel: 1 for loads, 2 for JAL/JALR, else 0.
  - pc_sel: 2 for JAL/JALR, else 0.
  - rd=x0 still asserts rd_wren; the regfile ignores it.
- HALT: all strobes 0, insn_vld=0; exit only by rst. illegal=1 if entered from DECODE.
- Watchdog (TIMEOUT_EN=1):
  - counts cycles in FETCH/MEM with ready=0; clears on ready or state change;
  - at 2^TIMEOUT_W-1 → HALT, bus_err=1, no strobes issued that cycle.
  - Ready arriving in the same cycle as timeout wins.
- instret increments on every retire; wraps to 0.
- Latency: ALU/jump 4 cycles, branch 3, store 4, load 5, each plus memory wait cycles.

Test Plan:
- ADD 0x002081B3, imem_ready=1 → states 0,1,2,4; EXEC alu_op=0000; WB rd_wren=1, wb_sel=0, pc_sel=0; retire in cycle 4; instret=1.
- OR 0x0020E1B3 → alu_op=0101; SRAI 0x4020D193 → alu_op=1001, opb_sel=1; ADDI with instr[30]=1 (0x4000_8193) → alu_op=0000.
- BNE 0x00209463: br_equal=0 → EXEC pc_wren=1, pc_sel=1. br_equal=1 → pc_sel=0. Both retire in 3 cycles, no rd_wren.
- LW 0x0080A283, dmem_ready after 3 cycles → dmem_req high 3 cycles, lsu_size=010, then WB wb_sel=1. SW 0x0050A423 → mem_wren=1, no WB.
- 0xFFFFFFFF → HALT, illegal=1, insn_vld=0, imem_req stays 0 until rst. rst → FETCH, illegal=0.
- TIMEOUT_W=4, imem_ready=0 → HALT after 15 wait cycles, bus_err=1. Ready at cycle 15 → normal fetch. rst asserted mid-MEM → FETCH next cycle, no mem_wren.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle control FSM with memory handshakes, watchdog and retire counter
// Datapath controls decode from state and IR; only flags, counters, watchdog and state are registered.
module multicycle_ctrl #(
  parameter bit TIMEOUT_EN = 1'b1,
  parameter int TIMEOUT_W  = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             br_less,
  input  logic             br_equal,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_wren,
  output logic             dmem_req,
  output logic             mem_wren,
  output logic [2:0]       lsu_size,
  output logic             alu_q_wren,
  output logic             pc_wren,
  output logic [1:0]       pc_sel,
  output logic             rd_wren,
  output logic             br_un,
  output logic [1:0]       opa_sel,
  output logic             opb_sel,
  output logic [3:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             insn_vld,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Timeout fires on the (2^TIMEOUT_W-1)th consecutive wait cycle, i.e. when the count already holds 2^TIMEOUT_W-2.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 illegal_q, bus_err_q;
  logic [CNT_W-1:0]     instret_q;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_r, is_imm, is_load, is_store, is_branch, is_jump, is_lui, is_auipc, is_jal;
  logic       legal, taken, waiting, timeout;
  logic [3:0] alu_fn;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign is_r      = (opcode == OP_R);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jump   = is_jal || (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    legal = 1'b1;
    case (opcode)
      OP_R:      legal = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_IMM: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
      end
      OP_BRANCH: legal = (funct3[2:1] != 2'b01);
      OP_LOAD:   legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      OP_STORE:  legal = (funct3 <= 3'b010);
      OP_JALR:   legal = (funct3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = br_equal;
      3'b001:         taken = !br_equal;
      3'b100, 3'b110: taken = br_less;
      3'b101, 3'b111: taken = !br_less;
      default:        taken = 1'b0;
    endcase
  end

  assign waiting = ((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready);
  assign timeout = TIMEOUT_EN && waiting && (wd_q == WD_LAST);
  assign wd_d    = (TIMEOUT_EN && waiting && !timeout) ? wd_q + WD_ONE : '0;

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_wren    = 1'b0;
    dmem_req   = 1'b0;
    mem_wren   = 1'b0;
    lsu_size   = 3'b000;
    alu_q_wren = 1'b0;
    pc_wren    = 1'b0;
    pc_sel     = 2'd0;
    rd_wren    = 1'b0;
    br_un      = 1'b0;
    opa_sel    = 2'd0;
    opb_sel    = 1'b0;
    alu_op     = ALU_ADD;
    wb_sel     = 2'd0;
    insn_vld   = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (timeout) begin
          state_d = S_HALT;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_wren = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        insn_vld = legal;
        state_d  = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        insn_vld   = 1'b1;
        alu_q_wren = 1'b1;
        opb_sel    = !is_r;
        alu_op     = (is_r || is_imm) ? alu_fn : ALU_ADD;
        if (is_lui)                            opa_sel = 2'd2;
        else if (is_auipc || is_jal || is_branch) opa_sel = 2'd1;
        else                                   opa_sel = 2'd0;
        if (is_branch) begin
          pc_wren = 1'b1;
          pc_sel  = taken ? 2'd1 : 2'd0;
          br_un   = funct3[1];
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        insn_vld = 1'b1;
        if (timeout) begin
          state_d = S_HALT;
        end else begin
          dmem_req = 1'b1;
          lsu_size = funct3;
          mem_wren = is_store;
          if (dmem_ready) begin
            if (is_store) begin
              pc_wren = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
      end
      S_WB: begin
        insn_vld = 1'b1;
        rd_wren  = 1'b1;
        pc_wren  = 1'b1;
        retire   = 1'b1;
        wb_sel   = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        pc_sel   = is_jump ? 2'd2 : 2'd0;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Reset cycle silences every control so an aborted MEM/WB never writes.
    if (rst) begin
      imem_req   = 1'b0;
      ir_wren    = 1'b0;
      dmem_req   = 1'b0;
      mem_wren   = 1'b0;
      lsu_size   = 3'b000;
      alu_q_wren = 1'b0;
      pc_wren    = 1'b0;
      pc_sel     = 2'd0;
      rd_wren    = 1'b0;
      br_un      = 1'b0;
      opa_sel    = 2'd0;
      opb_sel    = 1'b0;
      alu_op     = ALU_ADD;
      wb_sel     = 2'd0;
      insn_vld   = 1'b0;
      retire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (state_q == S_DECODE && !legal) illegal_q <= 1'b1;
      if (timeout)                       bus_err_q <= 1'b1;
      if (retire)                        instret_q <= instret_q + CNT_ONE;
    end
  end

  assign illegal = illegal_q && !rst;
  assign bus_err = bus_err_q && !rst;
  assign instret = rst ? '0 : instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = '0;
  logic br_less = 1'b0, br_equal = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, ir_wren, dmem_req, mem_wren, alu_q_wren, pc_wren, rd_wren, br_un, opb_sel;
  logic insn_vld, retire, illegal, bus_err;
  logic [2:0] lsu_size, state;
  logic [1:0] pc_sel, opa_sel, wb_sel;
  logic [3:0] alu_op;
  logic [CNT_W-1:0] instret;
  logic [CNT_W-1:0] exp_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_EN(1'b1), .TIMEOUT_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .br_less(br_less), .br_equal(br_equal),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_wren(ir_wren),
    .dmem_req(dmem_req), .mem_wren(mem_wren), .lsu_size(lsu_size), .alu_q_wren(alu_q_wren),
    .pc_wren(pc_wren), .pc_sel(pc_sel), .rd_wren(rd_wren), .br_un(br_un), .opa_sel(opa_sel),
    .opb_sel(opb_sel), .alu_op(alu_op), .wb_sel(wb_sel), .insn_vld(insn_vld), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .instret(instret), .state(state)
  );

  // {instr, alu_op, opa_sel, opb_sel}
  localparam logic [38:0] ALU_TAB [9] = '{
    {32'h002081B3, 4'b0000, 2'd0, 1'b0},  // ADD
    {32'h402081B3, 4'b0001, 2'd0, 1'b0},  // SUB
    {32'h0020E1B3, 4'b0101, 2'd0, 1'b0},  // OR
    {32'h0020B1B3, 4'b0011, 2'd0, 1'b0},  // SLTU
    {32'h4020D193, 4'b1001, 2'd0, 1'b1},  // SRAI
    {32'h40008193, 4'b0000, 2'd0, 1'b1},  // ADDI with bit30 set
    {32'h00309193, 4'b0111, 2'd0, 1'b1},  // SLLI
    {32'h123451B7, 4'b0000, 2'd2, 1'b1},  // LUI
    {32'h00001197, 4'b0000, 2'd1, 1'b1}   // AUIPC
  };
  // {instr, br_equal, br_less, pc_sel, br_un}
  localparam logic [36:0] BR_TAB [6] = '{
    {32'h00209463, 1'b0, 1'b0, 2'd1, 1'b0},  // BNE taken
    {32'h00209463, 1'b1, 1'b0, 2'd0, 1'b0},  // BNE not taken
    {32'h0020E463, 1'b0, 1'b1, 2'd1, 1'b1},  // BLTU taken
    {32'h0020D463, 1'b0, 1'b1, 2'd0, 1'b0},  // BGE not taken
    {32'h00208463, 1'b1, 1'b0, 2'd1, 1'b0},  // BEQ taken
    {32'h0020F463, 1'b0, 1'b0, 2'd1, 1'b1}   // BGEU taken
  };
  localparam logic [31:0] ILL_TAB [10] = '{
    32'hFFFFFFFF, 32'h0000000F, 32'h00000073, 32'h402091B3, 32'h0020A463,
    32'h0080B283, 32'h0050B423, 32'h000090E7, 32'h40309193, 32'h0230D193
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; br_less = 1'b0; br_equal = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = 32'h002081B3; imem_ready = 1'b1; dmem_ready = 1'b1;
    tick();
    checks++;
    if ({imem_req, ir_wren, dmem_req, mem_wren, alu_q_wren, pc_wren, rd_wren, retire, insn_vld, illegal, bus_err} !== 11'b0
        || state !== 3'd0 || instret !== '0) begin
      failures++;
      $display("FAIL reset_forced got imem_req=%b ir_wren=%b retire=%b state=%0d exp zeros", imem_req, ir_wren, retire, state);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({state, imem_req, ir_wren, illegal, bus_err} !== {3'd0, 4'b1100} || instret !== '0) begin
      failures++;
      $display("FAIL reset_release got state=%0d req=%b wren=%b ill=%b berr=%b cnt=%0d exp 0,1,1,0,0,0",
               state, imem_req, ir_wren, illegal, bus_err, instret);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] ins;
    logic [3:0]  op;
    logic [1:0]  opa;
    logic        opb;
    do_reset();
    exp_cnt = '0;
    for (int i = 0; i < 9; i++) begin
      {ins, op, opa, opb} = ALU_TAB[i];
      instr = ins; imem_ready = 1'b1;
      #1;
      checks++;
      if ({state, imem_req, ir_wren} !== {3'd0, 2'b11}) begin
        failures++;
        $display("FAIL alu%0d_fetch got state=%0d req=%b wren=%b exp 0,1,1", i, state, imem_req, ir_wren);
      end
      tick(); imem_ready = 1'b0; #1;
      checks++;
      if ({state, insn_vld} !== {3'd1, 1'b1}) begin
        failures++;
        $display("FAIL alu%0d_decode got state=%0d vld=%b exp 1,1", i, state, insn_vld);
      end
      tick();
      checks++;
      if ({state, alu_op, opa_sel, opb_sel, alu_q_wren, pc_wren, rd_wren, retire} !== {3'd2, op, opa, opb, 4'b1000}) begin
        failures++;
        $display("FAIL alu%0d_exec got state=%0d op=%b opa=%0d opb=%b aqw=%b exp 2,%b,%0d,%b,1", i, state, alu_op, opa_sel, opb_sel, alu_q_wren, op, opa, opb);
      end
      tick();
      checks++;
      if ({state, rd_wren, pc_wren, retire, wb_sel, pc_sel, alu_q_wren} !== {3'd4, 3'b111, 2'd0, 2'd0, 1'b0}) begin
        failures++;
        $display("FAIL alu%0d_wb got state=%0d rdw=%b pcw=%b ret=%b wb=%0d pcs=%0d exp 4,1,1,1,0,0", i, state, rd_wren, pc_wren, retire, wb_sel, pc_sel);
      end
      tick();
      exp_cnt++;
      checks++;
      if ({state, instret} !== {3'd0, exp_cnt}) begin
        failures++;
        $display("FAIL alu%0d_retired got state=%0d instret=%0d exp 0,%0d", i, state, instret, exp_cnt);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins;
    logic        eq, lt, un;
    logic [1:0]  ps;
    do_reset();
    exp_cnt = '0;
    for (int i = 0; i < 6; i++) begin
      {ins, eq, lt, ps, un} = BR_TAB[i];
      instr = ins; br_equal = eq; br_less = lt; imem_ready = 1'b1;
      tick(); imem_ready = 1'b0;
      tick();
      checks++;
      if ({state, pc_wren, pc_sel, retire, rd_wren, br_un, opa_sel, opb_sel, alu_op, alu_q_wren}
          !== {3'd2, 1'b1, ps, 1'b1, 1'b0, un, 2'd1, 1'b1, 4'd0, 1'b1}) begin
        failures++;
        $display("FAIL br%0d_exec got state=%0d pcw=%b pcs=%0d ret=%b rdw=%b brun=%b opa=%0d exp 2,1,%0d,1,0,%b,1", i, state, pc_wren, pc_sel, retire, rd_wren, br_un, opa_sel, ps, un);
      end
      tick();
      exp_cnt++;
      checks++;
      if ({state, instret} !== {3'd0, exp_cnt}) begin
        failures++;
        $display("FAIL br%0d_retired got state=%0d instret=%0d exp 0,%0d", i, state, instret, exp_cnt);
      end
    end
  endtask

  task automatic test_load_store();
    int bad;
    do_reset();
    instr = 32'h0080A283; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick();
    checks++;
    if ({state, opa_sel, opb_sel, alu_op, dmem_req} !== {3'd2, 2'd0, 1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL lw_exec got state=%0d opa=%0d opb=%b op=%b dreq=%b exp 2,0,1,0000,0", state, opa_sel, opb_sel, alu_op, dmem_req);
    end
    tick();
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      dmem_ready = (k == 2);
      #1;
      if ({state, dmem_req, mem_wren, lsu_size, retire, rd_wren} !== {3'd3, 1'b1, 1'b0, 3'b010, 2'b00}) bad++;
      tick();
    end
    dmem_ready = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL lw_mem got bad_cycles=%0d exp 0", bad);
    end
    #1;
    checks++;
    if ({state, wb_sel, rd_wren, pc_wren, pc_sel, retire} !== {3'd4, 2'd1, 2'b11, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL lw_wb got state=%0d wb=%0d rdw=%b pcs=%0d ret=%b exp 4,1,1,0,1", state, wb_sel, rd_wren, pc_sel, retire);
    end
    tick();
    instr = 32'h0050A423; imem_ready = 1'b1; dmem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({state, dmem_req, mem_wren, lsu_size, pc_wren, pc_sel, retire, rd_wren} !== {3'd3, 2'b11, 3'b010, 1'b1, 2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sw_mem got state=%0d dreq=%b mw=%b size=%b pcw=%b ret=%b rdw=%b exp 3,1,1,010,1,1,0", state, dmem_req, mem_wren, lsu_size, pc_wren, retire, rd_wren);
    end
    tick();
    dmem_ready = 1'b0;
    checks++;
    if ({state, instret} !== {3'd0, 4'd2}) begin
      failures++;
      $display("FAIL sw_retired got state=%0d instret=%0d exp 0,2", state, instret);
    end
  endtask

  task automatic test_jump();
    logic [31:0] ins [2];
    ins[0] = 32'h008000EF;
    ins[1] = 32'h000080E7;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      instr = ins[i]; imem_ready = 1'b1;
      tick(); imem_ready = 1'b0;
      tick();
      checks++;
      if ({state, opa_sel, opb_sel, alu_op, alu_q_wren, pc_wren} !== {3'd2, (i == 0) ? 2'd1 : 2'd0, 1'b1, 4'd0, 2'b10}) begin
        failures++;
        $display("FAIL jump%0d_exec got state=%0d opa=%0d opb=%b pcw=%b", i, state, opa_sel, opb_sel, pc_wren);
      end
      tick();
      checks++;
      if ({state, wb_sel, pc_sel, rd_wren, pc_wren, retire} !== {3'd4, 2'd2, 2'd2, 3'b111}) begin
        failures++;
        $display("FAIL jump%0d_wb got state=%0d wb=%0d pcs=%0d rdw=%b exp 4,2,2,1", i, state, wb_sel, pc_sel, rd_wren);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 10; i++) begin
      do_reset();
      instr = ILL_TAB[i]; imem_ready = 1'b1;
      tick();
      checks++;
      if ({state, insn_vld, illegal} !== {3'd1, 2'b00}) begin
        failures++;
        $display("FAIL ill%0d_decode got state=%0d vld=%b ill=%b exp 1,0,0", i, state, insn_vld, illegal);
      end
      tick(); tick(); tick();
      checks++;
      if ({state, illegal, insn_vld, imem_req, ir_wren, alu_q_wren} !== {3'd5, 1'b1, 4'b0000} || instret !== '0) begin
        failures++;
        $display("FAIL ill%0d_halt got state=%0d ill=%b vld=%b req=%b cnt=%0d exp 5,1,0,0,0", i, state, illegal, insn_vld, imem_req, instret);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; imem_ready = 1'b0;
      #1;
      checks++;
      if ({state, illegal} !== {3'd0, 1'b0}) begin
        failures++;
        $display("FAIL ill%0d_recover got state=%0d ill=%b exp 0,0", i, state, illegal);
      end
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    instr = 32'h002081B3;
    bad = 0;
    for (int k = 1; k <= 14; k++) begin
      if ({state, imem_req} !== {3'd0, 1'b1}) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL to_wait got bad_cycles=%0d exp 0", bad);
    end
    checks++;
    if ({state, imem_req, ir_wren, bus_err} !== {3'd0, 3'b000}) begin
      failures++;
      $display("FAIL to_fire_cycle got state=%0d req=%b berr=%b exp 0,0,0", state, imem_req, bus_err);
    end
    tick();
    imem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({state, bus_err, imem_req, ir_wren} !== {3'd5, 3'b100}) begin
      failures++;
      $display("FAIL to_halt got state=%0d berr=%b req=%b exp 5,1,0", state, bus_err, imem_req);
    end
    do_reset();
    for (int k = 1; k <= 14; k++) tick();
    imem_ready = 1'b1;
    #1;
    checks++;
    if ({state, imem_req, ir_wren} !== {3'd0, 2'b11}) begin
      failures++;
      $display("FAIL to_ready_wins got state=%0d req=%b wren=%b exp 0,1,1", state, imem_req, ir_wren);
    end
    tick();
    checks++;
    if ({state, bus_err} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL to_ready_next got state=%0d berr=%b exp 1,0", state, bus_err);
    end
    do_reset();
    instr = 32'h0080A283; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    bad = 0;
    for (int k = 1; k <= 14; k++) begin
      if ({state, dmem_req} !== {3'd3, 1'b1}) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || dmem_req !== 1'b0 || state !== 3'd3) begin
      failures++;
      $display("FAIL to_dmem_fire got bad_cycles=%0d dreq=%b state=%0d exp 0,0,3", bad, dmem_req, state);
    end
    tick();
    checks++;
    if ({state, bus_err} !== {3'd5, 1'b1}) begin
      failures++;
      $display("FAIL to_dmem_halt got state=%0d berr=%b exp 5,1", state, bus_err);
    end
  endtask

  task automatic test_wd_clear();
    do_reset();
    instr = 32'h0080A283;
    for (int k = 0; k < 10; k++) tick();
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 14; k++) tick();
    dmem_ready = 1'b1;
    #1;
    checks++;
    if ({state, dmem_req, bus_err} !== {3'd3, 2'b10}) begin
      failures++;
      $display("FAIL wd_clear_mem got state=%0d dreq=%b berr=%b exp 3,1,0", state, dmem_req, bus_err);
    end
    tick(); dmem_ready = 1'b0;
    checks++;
    if ({state, bus_err, wb_sel} !== {3'd4, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL wd_clear_wb got state=%0d berr=%b wb=%0d exp 4,0,1", state, bus_err, wb_sel);
    end
  endtask

  task automatic test_abort();
    do_reset();
    instr = 32'h0050A423; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({state, mem_wren} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL abort_pre got state=%0d mw=%b exp 3,1", state, mem_wren);
    end
    tick();
    rst = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++;
    if ({dmem_req, mem_wren, pc_wren, retire, rd_wren} !== 5'b0) begin
      failures++;
      $display("FAIL abort_mem_strobes got dreq=%b mw=%b pcw=%b ret=%b exp 0", dmem_req, mem_wren, pc_wren, retire);
    end
    tick();
    rst = 1'b0; dmem_ready = 1'b0;
    #1;
    checks++;
    if ({state, instret} !== {3'd0, 4'd0}) begin
      failures++;
      $display("FAIL abort_mem_next got state=%0d instret=%0d exp 0,0", state, instret);
    end
    instr = 32'h002081B3; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({state, rd_wren, pc_wren, retire} !== {3'd4, 3'b000}) begin
      failures++;
      $display("FAIL abort_wb got state=%0d rdw=%b pcw=%b ret=%b exp 4,0,0,0", state, rd_wren, pc_wren, retire);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_instret_wrap();
    do_reset();
    exp_cnt = '0;
    instr = 32'h00208463; br_equal = 1'b0;
    for (int i = 0; i < 17; i++) begin
      imem_ready = 1'b1;
      tick(); imem_ready = 1'b0;
      tick(); tick();
      exp_cnt++;
      if (i == 15 || i == 16) begin
        checks++;
        if ({state, instret} !== {3'd0, exp_cnt}) begin
          failures++;
          $display("FAIL wrap%0d got state=%0d instret=%0d exp 0,%0d", i, state, instret, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got time=%0t exp finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_branch();
    test_load_store();
    test_jump();
    test_illegal();
    test_timeout();
    test_wd_clear();
    test_abort();
    test_instret_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
